move_check_dispatcher: RTL and testbench

- Initiator side of the piece-checker interface. Accepts a move request from game control and pre-screens it against the board.
- Drives the per-piece checker (king/queen/rook/bishop/knight/pawn) with latched coordinates, deltas and piece type, plus a one-cycle start.
- Waits for that checker's done, then returns a legal/illegal verdict with a reason code over a valid/ready response handshake.

---
 rtl/move_check_dispatcher.sv | 267 ++++++++++++++++++++++++++
 tb/tb_move_check_dispatcher.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/move_check_dispatcher.sv
// move_check_dispatcher: initiator side of the piece-checker interface.
// Accepts a move request, pre-screens it against the board, dispatches a
// one-cycle start to the matching piece checker, waits for its done (bounded
// by TIMEOUT_CYCLES) and returns a verdict over a valid/ready handshake.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_old_*/req_new_*, turn  move coordinates and side to move
//   board_in                   board [y][x] of 4-bit piece codes
//   chk_*                      latched move info and one-hot start to checkers
//   chk_valid_move, chk_done   per-checker verdict and completion
//   resp_valid/resp_ready      response handshake
//   resp_legal, resp_code      verdict and reason code
//
// Optional: define MOVE_STATS_EN to add stat_legal_cnt / stat_reject_cnt,
// saturating 16-bit counters of legal and rejected response handshakes.
module move_check_dispatcher #(
    parameter int unsigned TIMEOUT_CYCLES = 64,
    parameter int unsigned TO_W           = 7,
    localparam int unsigned CW            = 3,
    localparam int unsigned PW            = 4,
    localparam int unsigned NCHK          = 6
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [CW-1:0]              req_old_x,
    input  logic [CW-1:0]              req_old_y,
    input  logic [CW-1:0]              req_new_x,
    input  logic [CW-1:0]              req_new_y,
    input  logic                       turn,
    input  logic [7:0][7:0][PW-1:0]    board_in,
    output logic [CW-1:0]              chk_old_x,
    output logic [CW-1:0]              chk_old_y,
    output logic [CW-1:0]              chk_new_x,
    output logic [CW-1:0]              chk_new_y,
    output logic [CW-1:0]              chk_h_delta,
    output logic [CW-1:0]              chk_v_delta,
    output logic [PW-1:0]              chk_piece_type,
    output logic [NCHK-1:0]            chk_start,
    input  logic [NCHK-1:0]            chk_valid_move,
    input  logic [NCHK-1:0]            chk_done,
    output logic                       resp_valid,
    input  logic                       resp_ready,
    output logic                       resp_legal,
    output logic [2:0]                 resp_code
`ifdef MOVE_STATS_EN
    ,
    output logic [15:0]                stat_legal_cnt,
    output logic [15:0]                stat_reject_cnt
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRECHECK,
        S_DISPATCH,
        S_WAIT,
        S_RESP
    } state_t;

    localparam logic [PW-1:0] PC_EMPTY     = 4'd15;
    localparam logic [PW-1:0] PC_FIRST_BAD = 4'd12;
    localparam logic [PW-1:0] PC_BLACK     = 4'd6;

    localparam logic [2:0] CODE_LEGAL     = 3'd0;
    localparam logic [2:0] CODE_NULL      = 3'd1;
    localparam logic [2:0] CODE_EMPTY     = 3'd2;
    localparam logic [2:0] CODE_BAD_PIECE = 3'd3;
    localparam logic [2:0] CODE_WRONG_COL = 3'd4;
    localparam logic [2:0] CODE_OWN_CAP   = 3'd5;
    localparam logic [2:0] CODE_ILLEGAL   = 3'd6;
    localparam logic [2:0] CODE_TIMEOUT   = 3'd7;

    state_t            state_q, state_d;
    logic              turn_q, turn_d;
    logic [2:0]        cls_q, cls_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              req_ready_q, req_ready_d;
    logic [CW-1:0]     old_x_q, old_x_d, old_y_q, old_y_d;
    logic [CW-1:0]     new_x_q, new_x_d, new_y_q, new_y_d;
    logic [CW-1:0]     h_delta_q, h_delta_d, v_delta_q, v_delta_d;
    logic [PW-1:0]     ptype_q, ptype_d;
    logic [NCHK-1:0]   start_q, start_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_legal_q, resp_legal_d;
    logic [2:0]        resp_code_q, resp_code_d;

    // Checker index of a valid piece code (code mod 6).
    function automatic logic [2:0] piece_class(input logic [PW-1:0] code);
        return (code >= PC_BLACK) ? 3'(code - PC_BLACK) : code[2:0];
    endfunction

    // Pre-check operands; coordinates are already latched at accept.
    logic [PW-1:0] src, dst;
    logic [CW-1:0] h_abs, v_abs;
    logic          src_col, dst_col;

    assign src     = board_in[old_y_q][old_x_q];
    assign dst     = board_in[new_y_q][new_x_q];
    assign h_abs   = (new_x_q >= old_x_q) ? (new_x_q - old_x_q) : (old_x_q - new_x_q);
    assign v_abs   = (new_y_q >= old_y_q) ? (new_y_q - old_y_q) : (old_y_q - new_y_q);
    assign src_col = (src >= PC_BLACK);
    assign dst_col = (dst >= PC_BLACK);

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            turn_q       <= 1'b0;
            cls_q        <= '0;
            to_cnt_q     <= '0;
            req_ready_q  <= 1'b1;
            old_x_q      <= '0;
            old_y_q      <= '0;
            new_x_q      <= '0;
            new_y_q      <= '0;
            h_delta_q    <= '0;
            v_delta_q    <= '0;
            ptype_q      <= '0;
            start_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_legal_q <= 1'b0;
            resp_code_q  <= '0;
        end else begin
            state_q      <= state_d;
            turn_q       <= turn_d;
            cls_q        <= cls_d;
            to_cnt_q     <= to_cnt_d;
            req_ready_q  <= req_ready_d;
            old_x_q      <= old_x_d;
            old_y_q      <= old_y_d;
            new_x_q      <= new_x_d;
            new_y_q      <= new_y_d;
            h_delta_q    <= h_delta_d;
            v_delta_q    <= v_delta_d;
            ptype_q      <= ptype_d;
            start_q      <= start_d;
            resp_valid_q <= resp_valid_d;
            resp_legal_q <= resp_legal_d;
            resp_code_q  <= resp_code_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state_q;
        turn_d       = turn_q;
        cls_d        = cls_q;
        to_cnt_d     = to_cnt_q;
        old_x_d      = old_x_q;
        old_y_d      = old_y_q;
        new_x_d      = new_x_q;
        new_y_d      = new_y_q;
        h_delta_d    = h_delta_q;
        v_delta_d    = v_delta_q;
        ptype_d      = ptype_q;
        start_d      = '0;
        resp_valid_d = resp_valid_q;
        resp_legal_d = resp_legal_q;
        resp_code_d  = resp_code_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    old_x_d = req_old_x;
                    old_y_d = req_old_y;
                    new_x_d = req_new_x;
                    new_y_d = req_new_y;
                    turn_d  = turn;
                    state_d = S_PRECHECK;
                end
            end
            S_PRECHECK: begin
                ptype_d      = src;
                h_delta_d    = h_abs;
                v_delta_d    = v_abs;
                cls_d        = piece_class(src);
                resp_legal_d = 1'b0;
                resp_valid_d = 1'b1;
                state_d      = S_RESP;
                if (old_x_q == new_x_q && old_y_q == new_y_q) begin
                    resp_code_d = CODE_NULL;
                end else if (src == PC_EMPTY) begin
                    resp_code_d = CODE_EMPTY;
                end else if (src >= PC_FIRST_BAD) begin
                    resp_code_d = CODE_BAD_PIECE;
                end else if (src_col != turn_q) begin
                    resp_code_d = CODE_WRONG_COL;
                end else if (dst != PC_EMPTY && dst_col == turn_q) begin
                    resp_code_d = CODE_OWN_CAP;
                end else begin
                    resp_valid_d = 1'b0;
                    start_d      = NCHK'(1) << piece_class(src);
                    state_d      = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                // Done has priority over a simultaneous timeout expiry.
                if (chk_done[cls_q]) begin
                    resp_legal_d = chk_valid_move[cls_q];
                    resp_code_d  = chk_valid_move[cls_q] ? CODE_LEGAL : CODE_ILLEGAL;
                    resp_valid_d = 1'b1;
                    state_d      = S_RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                    if (to_cnt_d == TO_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_legal_d = 1'b0;
                        resp_code_d  = CODE_TIMEOUT;
                        resp_valid_d = 1'b1;
                        state_d      = S_RESP;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    assign req_ready      = req_ready_q;
    assign chk_old_x      = old_x_q;
    assign chk_old_y      = old_y_q;
    assign chk_new_x      = new_x_q;
    assign chk_new_y      = new_y_q;
    assign chk_h_delta    = h_delta_q;
    assign chk_v_delta    = v_delta_q;
    assign chk_piece_type = ptype_q;
    assign chk_start      = start_q;
    assign resp_valid     = resp_valid_q;
    assign resp_legal     = resp_legal_q;
    assign resp_code      = resp_code_q;

`ifdef MOVE_STATS_EN
    logic [15:0] stat_legal_q, stat_reject_q;

    // Saturating verdict counters, bumped on each response handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_legal_q  <= '0;
            stat_reject_q <= '0;
        end else if (state_q == S_RESP && resp_ready) begin
            if (resp_code_q == CODE_LEGAL) begin
                if (stat_legal_q != 16'hFFFF) stat_legal_q <= stat_legal_q + 16'd1;
            end else begin
                if (stat_reject_q != 16'hFFFF) stat_reject_q <= stat_reject_q + 16'd1;
            end
        end
    end

    assign stat_legal_cnt  = stat_legal_q;
    assign stat_reject_cnt = stat_reject_q;
`endif

endmodule

// File: tb/tb_move_check_dispatcher.sv
// Self-checking bench for move_check_dispatcher: directed cases plus random
// boards/requests against a rule-level reference model and a stub checker.
module tb_move_check_dispatcher;

    localparam int unsigned T = 16;

    logic                    clk = 1'b0;
    logic                    reset_n;
    logic                    req_valid;
    logic                    req_ready;
    logic [2:0]              req_old_x, req_old_y, req_new_x, req_new_y;
    logic                    turn;
    logic [7:0][7:0][3:0]    board;
    logic [2:0]              chk_old_x, chk_old_y, chk_new_x, chk_new_y;
    logic [2:0]              chk_h_delta, chk_v_delta;
    logic [3:0]              chk_piece_type;
    logic [5:0]              chk_start;
    logic [5:0]              chk_valid_move, chk_done;
    logic                    resp_valid, resp_ready, resp_legal;
    logic [2:0]              resp_code;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    move_check_dispatcher #(.TIMEOUT_CYCLES(T), .TO_W(5)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_old_x(req_old_x), .req_old_y(req_old_y),
        .req_new_x(req_new_x), .req_new_y(req_new_y),
        .turn(turn), .board_in(board),
        .chk_old_x(chk_old_x), .chk_old_y(chk_old_y),
        .chk_new_x(chk_new_x), .chk_new_y(chk_new_y),
        .chk_h_delta(chk_h_delta), .chk_v_delta(chk_v_delta),
        .chk_piece_type(chk_piece_type), .chk_start(chk_start),
        .chk_valid_move(chk_valid_move), .chk_done(chk_done),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_legal(resp_legal), .resp_code(resp_code)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Pre-check verdict straight from the move rules (0 = passes to checker).
    function automatic int model_precheck(input int ox, input int oy, input int nx, input int ny, input int t);
        int s, d;
        s = int'(board[oy][ox]);
        d = int'(board[ny][nx]);
        if (ox == nx && oy == ny) return 1;
        if (s == 15) return 2;
        if (s >= 12) return 3;
        if ((s >= 6 ? 1 : 0) != t) return 4;
        if (d != 15 && (d >= 6 ? 1 : 0) == t) return 5;
        return 0;
    endfunction

    function automatic int absdiff(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    task automatic init_board();
        int back[8] = '{2, 4, 3, 1, 0, 3, 4, 2};
        for (int x = 0; x < 8; x++) begin
            board[0][x] = 4'(back[x] + 6);
            board[1][x] = 4'd11;
            for (int y = 2; y < 6; y++) board[y][x] = 4'd15;
            board[6][x] = 4'd5;
            board[7][x] = 4'(back[x]);
        end
    endtask

    task automatic drive_req(input int ox, input int oy, input int nx, input int ny, input int t);
        req_valid = 1'b1;
        req_old_x = 3'(ox); req_old_y = 3'(oy);
        req_new_x = 3'(nx); req_new_y = 3'(ny);
        turn      = t[0];
    endtask

    // One request end to end. dly: cycles from start pulse to the checker's
    // one-cycle done; hold: cycles resp_ready stays low once resp_valid rises.
    task automatic run_txn(input int ox, input int oy, input int nx, input int ny, input int t,
                           input int dly, input bit vbit, input int hold);
        int pre, cls, r_exp, r_seen, exp_code;
        bit pass, exp_legal;
        logic [5:0] onehot;
        pre    = model_precheck(ox, oy, nx, ny, t);
        pass   = (pre == 0);
        cls    = int'(board[oy][ox]) % 6;
        onehot = pass ? 6'(1 << cls) : 6'd0;
        if (!pass) begin
            r_exp = 2; exp_code = pre; exp_legal = 1'b0;
        end else if (dly <= int'(T) - 1) begin
            r_exp = 3 + dly; exp_code = vbit ? 0 : 6; exp_legal = vbit;
        end else begin
            r_exp = 2 + int'(T); exp_code = 7; exp_legal = 1'b0;
        end

        @(negedge clk);
        check_eq("req_ready_idle", 32'(req_ready), 32'd1);
        drive_req(ox, oy, nx, ny, t);
        @(negedge clk);
        req_valid = 1'b0;
        r_seen = -1;
        for (int cyc = 1; cyc <= int'(T) + 40 && r_seen < 0; cyc++) begin
            if (cyc > 1) @(negedge clk);
            check_eq("req_ready_busy", 32'(req_ready), 32'd0);
            check_eq("chk_start", 32'(chk_start), (cyc == 2) ? 32'(onehot) : 32'd0);
            if (cyc == 2) begin
                check_eq("chk_piece_type", 32'(chk_piece_type), 32'(board[oy][ox]));
                check_eq("chk_h_delta", 32'(chk_h_delta), 32'(absdiff(nx, ox)));
                check_eq("chk_v_delta", 32'(chk_v_delta), 32'(absdiff(ny, oy)));
                check_eq("chk_coords", {20'd0, chk_old_x, chk_old_y, chk_new_x, chk_new_y},
                         32'((ox << 9) | (oy << 6) | (nx << 3) | ny));
            end
            chk_done       = 6'($urandom) & ~onehot;
            chk_valid_move = 6'($urandom);
            if (resp_valid) begin
                r_seen = cyc;
                chk_done = '0;
            end else if (pass && cyc == 2 + dly) begin
                chk_done[cls]       = 1'b1;
                chk_valid_move[cls] = vbit;
            end
        end
        if (r_seen < 0) begin
            check_eq("resp_valid_seen", 32'(resp_valid), 32'd1);
            return;
        end
        check_eq("resp_latency", 32'(r_seen), 32'(r_exp));
        check_eq("resp_code", 32'(resp_code), 32'(exp_code));
        check_eq("resp_legal", 32'(resp_legal), 32'(exp_legal));
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk_done = '0;
            check_eq("hold_valid", 32'(resp_valid), 32'd1);
            check_eq("hold_code", 32'(resp_code), 32'(exp_code));
            check_eq("hold_legal", 32'(resp_legal), 32'(exp_legal));
            check_eq("hold_req_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        check_eq("post_hs_valid", 32'(resp_valid), 32'd0);
        check_eq("post_hs_req_ready", 32'(req_ready), 32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check_eq({tag, "_resp"}, {28'd0, resp_valid, resp_legal, resp_code == 3'd0, 1'b0}, 32'h2);
        check_eq({tag, "_start"}, 32'(chk_start), 32'd0);
        check_eq({tag, "_chk"}, {8'd0, chk_old_x, chk_old_y, chk_new_x, chk_new_y,
                                 chk_h_delta, chk_v_delta, chk_piece_type}, 32'd0);
    endtask

    // Knight request whose checker never answers; reset lands at cycle at_cyc.
    task automatic reset_mid(input int at_cyc);
        init_board();
        @(negedge clk);
        drive_req(6, 7, 5, 5, 0);
        @(negedge clk);
        req_valid = 1'b0;
        for (int cyc = 1; cyc < at_cyc; cyc++) @(negedge clk);
        if (at_cyc == 2) check_eq("pre_reset_start", 32'(chk_start), 32'h10);
        reset_n = 1'b0;
        #1;
        check_reset_values("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        run_txn(4, 6, 4, 4, 0, 1, 1'b1, 0);
    endtask

    initial begin
        reset_n = 1'b0;
        req_valid = 1'b0; resp_ready = 1'b0;
        req_old_x = '0; req_old_y = '0; req_new_x = '0; req_new_y = '0; turn = 1'b0;
        chk_done = '0; chk_valid_move = '0;
        init_board();
        repeat (3) @(negedge clk);
        check_reset_values("reset");
        reset_n = 1'b1;

        // Directed cases from the move rules.
        run_txn(4, 6, 4, 4, 0, 1, 1'b1, 0);          // pawn double step, legal
        run_txn(3, 3, 3, 3, 0, 1, 1'b1, 0);          // null move
        run_txn(0, 4, 0, 3, 0, 1, 1'b1, 0);          // empty source
        run_txn(1, 7, 2, 5, 1, 1, 1'b1, 0);          // black to move, white knight
        run_txn(0, 7, 0, 6, 0, 1, 1'b1, 0);          // rook onto own pawn
        run_txn(1, 7, 2, 5, 0, 1000, 1'b1, 0);       // checker never done
        run_txn(1, 7, 2, 5, 0, 1, 1'b0, 5);          // illegal, response held
        run_txn(6, 7, 5, 5, 0, int'(T) - 1, 1'b1, 0); // done on expiry cycle wins
        run_txn(6, 7, 5, 5, 0, int'(T), 1'b1, 0);    // done one cycle too late
        board[4][4] = 4'd13;
        run_txn(4, 4, 5, 5, 0, 1, 1'b1, 0);          // invalid piece code
        reset_mid(5);
        reset_mid(2);

        // Random boards and requests.
        for (int n = 0; n < 80; n++) begin
            int ox, oy, nx, ny, t, r;
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++) begin
                    r = int'($urandom_range(0, 99));
                    if (r < 50)      board[y][x] = 4'd15;
                    else if (r < 94) board[y][x] = 4'($urandom_range(0, 11));
                    else             board[y][x] = 4'($urandom_range(12, 14));
                end
            ox = int'($urandom_range(0, 7)); oy = int'($urandom_range(0, 7));
            nx = int'($urandom_range(0, 7)); ny = int'($urandom_range(0, 7));
            t  = int'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 1) board[oy][ox] = 4'(t * 6 + int'($urandom_range(0, 5)));
            run_txn(ox, oy, nx, ny, t, int'($urandom_range(1, T + 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errs);
        $fatal(1);
    end

endmodule
